// File: rtl/pulsein_decoder.sv
// Purpose: decodes a two-pulse serial PWM frame into left/right 5-bit motor commands {power[2:0], dir[1:0]}.
// Latency: MC1/MC2/FRAME_VALID update on the 3rd CLK edge after PWM_IN is first sampled low at the end of pulse 2 (+GLITCH_CYCLES with filter).
// Backpressure: none; the line is free-running, malformed frames are dropped with FRAME_ERR. Optional filter: PULSEIN_GLITCH_FILTER_EN.
module pulsein_decoder #(
    parameter int NEUTRAL_CYCLES = 150000,
    parameter int STEP_CYCLES    = 3125,
    parameter int MIN_W          = 90000,
    parameter int MAX_W          = 210000,
    parameter int SYNC_GAP       = 400000,
    parameter int TIMEOUT        = 3000000,
    parameter int GLITCH_CYCLES  = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PWM_IN,
    output logic [4:0] MC1,
    output logic [4:0] MC2,
    output logic       FRAME_VALID,
    output logic       FRAME_ERR,
    output logic       LINK_OK
);

    localparam logic [21:0] NEU_L = 22'(NEUTRAL_CYCLES);
    localparam logic [21:0] MIN_L = 22'(MIN_W);
    localparam logic [21:0] MAX_L = 22'(MAX_W);
    localparam logic [21:0] GAP_L = 22'(SYNC_GAP);
    localparam logic [21:0] TO_L  = 22'(TIMEOUT);
    localparam logic [4:0]  MC_NEUTRAL = 5'b00001;

    typedef enum logic [2:0] {HUNT, ARMED, P1, GAP, P2} state_t;

    state_t      state, state_nxt;
    logic [21:0] run_cnt, run_nxt, run_inc;
    logic [21:0] w1, w1_nxt;
    logic [21:0] to_cnt;
    logic        pwm_s1, pwm_s2, pwm_q, pwm_d;
    logic        rise, fall;
    logic        frame_ok, frame_bad;

    // Two-flop synchronizer for the asynchronous line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_s1 <= 1'b0;
            pwm_s2 <= 1'b0;
        end else begin
            pwm_s1 <= PWM_IN;
            pwm_s2 <= pwm_s1;
        end
    end

`ifdef PULSEIN_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic [GW-1:0] glitch_cnt;
    logic          pwm_f;

    // Accept a new level only after GLITCH_CYCLES consecutive differing samples; both edges get the same delay.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_f      <= 1'b0;
            glitch_cnt <= '0;
        end else if (pwm_s2 == pwm_f) begin
            glitch_cnt <= '0;
        end else if (glitch_cnt == GW'(GLITCH_CYCLES - 1)) begin
            pwm_f      <= pwm_s2;
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
    assign pwm_q = pwm_f;
`else
    assign pwm_q = pwm_s2;
`endif

    // Delayed copy of the cleaned line for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pwm_d <= 1'b0;
        else     pwm_d <= pwm_q;
    end

    assign rise    = pwm_q & ~pwm_d;
    assign fall    = ~pwm_q & pwm_d;
    assign run_inc = (run_cnt == '1) ? run_cnt : run_cnt + 22'd1;

    // Width -> command via threshold compares: level = floor((|delta| + STEP/2) / STEP), clamped to 8.
    function automatic logic [4:0] decode(input logic [21:0] w);
        logic        pos;
        logic [22:0] mag;
        logic [22:0] biased;
        logic [3:0]  level;
        pos    = (w > NEU_L);
        mag    = pos ? {1'b0, w - NEU_L} : {1'b0, NEU_L - w};
        biased = mag + 23'(STEP_CYCLES / 2);
        level  = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if (biased >= 23'(k * STEP_CYCLES)) level = 4'(k);
        end
        if (level == 4'd0) decode = MC_NEUTRAL;
        else               decode = {3'(level - 4'd1), pos ? 2'b00 : 2'b10};
    endfunction

    // FSM state, run counter and first-pulse width registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= HUNT;
            run_cnt <= '0;
            w1      <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
            w1      <= w1_nxt;
        end
    end

    // Next-state: the run counter includes the current cycle, so at a falling edge it equals the pulse width.
    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        w1_nxt    = w1;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            HUNT: begin
                if (pwm_q) begin
                    run_nxt = '0;
                end else begin
                    run_nxt = run_inc;
                    if (run_inc >= GAP_L) state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    run_nxt   = 22'd1;
                    state_nxt = P1;
                end
            end
            P1, P2: begin
                if (fall) begin
                    run_nxt   = '0;
                    if (run_cnt >= MIN_L && run_cnt <= MAX_L) begin
                        if (state == P1) begin
                            w1_nxt    = run_cnt;
                            run_nxt   = 22'd1;
                            state_nxt = GAP;
                        end else begin
                            frame_ok  = 1'b1;
                            state_nxt = HUNT;
                        end
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = HUNT;
                    end
                end else if (run_cnt >= MAX_L) begin
                    frame_bad = 1'b1;
                    run_nxt   = '0;
                    state_nxt = HUNT;
                end else begin
                    run_nxt = run_inc;
                end
            end
            GAP: begin
                if (rise) begin
                    run_nxt   = 22'd1;
                    state_nxt = P2;
                end else if (run_inc >= GAP_L) begin
                    frame_bad = 1'b1;
                    run_nxt   = '0;
                    state_nxt = ARMED;
                end else begin
                    run_nxt = run_inc;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Output registers and link timeout; a valid frame takes priority over an expiring timeout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MC1         <= MC_NEUTRAL;
            MC2         <= MC_NEUTRAL;
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            LINK_OK     <= 1'b0;
            to_cnt      <= '0;
        end else begin
            FRAME_VALID <= frame_ok;
            FRAME_ERR   <= frame_bad;
            if (frame_ok) begin
                MC1     <= decode(w1);
                MC2     <= decode(run_cnt);
                LINK_OK <= 1'b1;
                to_cnt  <= '0;
            end else if (to_cnt >= TO_L - 22'd1) begin
                MC1     <= MC_NEUTRAL;
                MC2     <= MC_NEUTRAL;
                LINK_OK <= 1'b0;
                to_cnt  <= TO_L;
            end else begin
                to_cnt  <= to_cnt + 22'd1;
            end
        end
    end

endmodule

// File: tb/tb_pulsein_decoder.sv
// Bench for pulsein_decoder with scaled-down timing parameters.
// Expected commands are pushed to a queue as frames are driven and popped on FRAME_VALID.
// Each task checks its own scenario inline.
module tb_pulsein_decoder;

    localparam int NEU  = 300;
    localparam int STP  = 10;
    localparam int MINW = 180;
    localparam int MAXW = 420;
    localparam int SGAP = 800;
    localparam int TMO  = 6000;
    localparam int GLT  = 8;
`ifdef PULSEIN_GLITCH_FILTER_EN
    localparam int LAT = 3 + GLT;
`else
    localparam int LAT = 3;
`endif
    localparam int LEAD = 1000;
    localparam int HOLD = 240;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PWM_IN = 1'b0;
    logic [4:0] MC1, MC2;
    logic       FRAME_VALID, FRAME_ERR, LINK_OK;

    int n_cmp = 0;
    int n_bad = 0;
    int n_val = 0;
    int n_err = 0;
    int exp_err = 0;
    logic [9:0] exp_q[$];

    pulsein_decoder #(
        .NEUTRAL_CYCLES(NEU), .STEP_CYCLES(STP), .MIN_W(MINW), .MAX_W(MAXW),
        .SYNC_GAP(SGAP), .TIMEOUT(TMO), .GLITCH_CYCLES(GLT)
    ) dut (
        .CLK(CLK), .RST(RST), .PWM_IN(PWM_IN), .MC1(MC1), .MC2(MC2),
        .FRAME_VALID(FRAME_VALID), .FRAME_ERR(FRAME_ERR), .LINK_OK(LINK_OK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4:0] model(input int w);
        int d, mag, lvl;
        d   = w - NEU;
        mag = (d < 0) ? -d : d;
        lvl = (mag + STP / 2) / STP;
        if (lvl > 8) lvl = 8;
        if (lvl == 0) return 5'b00001;
        return {3'(lvl - 1), (d > 0) ? 2'b00 : 2'b10};
    endfunction

    function automatic bit w_ok(input int w);
        return (w >= MINW) && (w <= MAXW);
    endfunction

    // Scoreboard monitor: every FRAME_VALID pops one expected command pair.
    always @(negedge CLK) begin
        if (!RST) begin
            if (FRAME_VALID) begin
                logic [9:0] e;
                n_val++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_frame_valid: got MC1=%b MC2=%b, required no strobe", MC1, MC2);
                end else begin
                    e = exp_q.pop_front();
                    if ({MC1, MC2} !== e) begin
                        n_bad++;
                        $display("FAIL frame_decode: got MC1=%b MC2=%b, required MC1=%b MC2=%b", MC1, MC2, e[9:5], e[4:0]);
                    end
                end
            end
            if (FRAME_ERR) n_err++;
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            PWM_IN = v;
        end
    endtask

    task automatic send_frame(input int w1, input int w2, input int lead, output int lat);
        if (!w_ok(w1) || !w_ok(w2)) exp_err++;
        else exp_q.push_back({model(w1), model(w2)});
        drive(1'b0, lead);
        drive(1'b1, w1);
        drive(1'b0, HOLD);
        drive(1'b1, w2);
        drive(1'b0, 1);
        lat = -1;
        for (int i = 1; i <= LAT + 10; i++) begin
            @(negedge CLK);
            if (FRAME_VALID && lat < 0) lat = i;
        end
    endtask

    task automatic check_counts(input string tag);
        n_cmp++;
        if (n_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s_err_count: got %0d, required %0d", tag, n_err, exp_err);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_pending: got %0d undecoded frames, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({MC1, MC2, FRAME_VALID, FRAME_ERR, LINK_OK} !== {5'b00001, 5'b00001, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_values: got MC1=%b MC2=%b FV=%b FE=%b LINK=%b, required 00001 00001 0 0 0",
                     MC1, MC2, FRAME_VALID, FRAME_ERR, LINK_OK);
        end
        RST = 1'b0;
        drive(1'b0, 200);
        n_cmp++;
        if ({MC1, MC2, LINK_OK} !== {5'b00001, 5'b00001, 1'b0} || n_val !== 0 || n_err !== 0) begin
            n_bad++;
            $display("FAIL idle_low: got MC1=%b MC2=%b LINK=%b valids=%0d errs=%0d, required 00001 00001 0 0 0",
                     MC1, MC2, LINK_OK, n_val, n_err);
        end
    endtask

    task automatic test_decode_basic();
        int lat;
        send_frame(340, 200, LEAD, lat);
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++;
            $display("FAIL latency: got %0d, required %0d", lat, LAT);
        end
        n_cmp++;
        if ({MC1, MC2, LINK_OK} !== {5'b01100, 5'b11110, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_outputs: got MC1=%b MC2=%b LINK=%b, required 01100 11110 1", MC1, MC2, LINK_OK);
        end
        n_cmp++;
        if (n_val !== 1) begin
            n_bad++;
            $display("FAIL basic_strobes: got %0d valids, required 1", n_val);
        end
        check_counts("basic");
    endtask

    task automatic test_neutral_clamp();
        int lat;
        send_frame(301, 296, LEAD, lat);
        n_cmp++;
        if ({MC1, MC2} !== {5'b00001, 5'b00001}) begin
            n_bad++;
            $display("FAIL neutral: got MC1=%b MC2=%b, required 00001 00001", MC1, MC2);
        end
        send_frame(377, 305, LEAD, lat);
        n_cmp++;
        if ({MC1, MC2} !== {5'b11100, 5'b00000}) begin
            n_bad++;
            $display("FAIL clamp: got MC1=%b MC2=%b, required 11100 00000", MC1, MC2);
        end
        send_frame(304, 295, LEAD, lat);
        send_frame(MINW, MAXW, LEAD, lat);
        n_cmp++;
        if ({MC1, MC2} !== {5'b11110, 5'b11100}) begin
            n_bad++;
            $display("FAIL width_limits: got MC1=%b MC2=%b, required 11110 11100", MC1, MC2);
        end
        check_counts("neutral_clamp");
    endtask

    task automatic test_bad_width();
        int lat;
        send_frame(500, 300, LEAD, lat);
        n_cmp++;
        if ({MC1, MC2} !== {5'b11110, 5'b11100}) begin
            n_bad++;
            $display("FAIL too_long_hold: got MC1=%b MC2=%b, required 11110 11100", MC1, MC2);
        end
        check_counts("too_long");
        send_frame(MINW - 1, 300, LEAD, lat);
        check_counts("too_short");
        send_frame(330, 270, LEAD, lat);
        n_cmp++;
        if ({MC1, MC2} !== {5'b01000, 5'b01010}) begin
            n_bad++;
            $display("FAIL recover_after_err: got MC1=%b MC2=%b, required 01000 01010", MC1, MC2);
        end
        check_counts("recover");
    endtask

    task automatic test_missing_p2();
        int lat;
        drive(1'b0, LEAD);
        drive(1'b1, 300);
        exp_err++;
        drive(1'b0, SGAP + 200);
        check_counts("missing_p2");
        send_frame(320, 280, 0, lat);
        n_cmp++;
        if ({MC1, MC2} !== {5'b00100, 5'b00110} || lat !== LAT) begin
            n_bad++;
            $display("FAIL after_missing_p2: got MC1=%b MC2=%b lat=%0d, required 00100 00110 lat=%0d", MC1, MC2, lat, LAT);
        end
        check_counts("rearmed");
    endtask

    task automatic test_reset_mid_p1();
        int lat;
        send_frame(340, 200, LEAD, lat);
        drive(1'b0, LEAD);
        drive(1'b1, 150);
        @(negedge CLK);
        RST = 1'b1;
        drive(1'b1, 3);
        n_cmp++;
        if ({MC1, MC2, LINK_OK, FRAME_VALID, FRAME_ERR} !== {5'b00001, 5'b00001, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_mid_p1: got MC1=%b MC2=%b LINK=%b FV=%b FE=%b, required 00001 00001 0 0 0",
                     MC1, MC2, LINK_OK, FRAME_VALID, FRAME_ERR);
        end
        RST = 1'b0;
        drive(1'b1, 50);
        drive(1'b0, 20);
        send_frame(330, 270, LEAD, lat);
        n_cmp++;
        if ({MC1, MC2, LINK_OK} !== {5'b01000, 5'b01010, 1'b1}) begin
            n_bad++;
            $display("FAIL frame_after_reset: got MC1=%b MC2=%b LINK=%b, required 01000 01010 1", MC1, MC2, LINK_OK);
        end
        check_counts("reset_mid_p1");
    endtask

    task automatic test_timeout();
        int lat;
        send_frame(340, 200, LEAD, lat);
        drive(1'b0, TMO - 100);
        n_cmp++;
        if ({LINK_OK, MC1} !== {1'b1, 5'b01100}) begin
            n_bad++;
            $display("FAIL before_timeout: got LINK=%b MC1=%b, required 1 01100", LINK_OK, MC1);
        end
        drive(1'b0, 200);
        n_cmp++;
        if ({LINK_OK, MC1, MC2} !== {1'b0, 5'b00001, 5'b00001}) begin
            n_bad++;
            $display("FAIL after_timeout: got LINK=%b MC1=%b MC2=%b, required 0 00001 00001", LINK_OK, MC1, MC2);
        end
        check_counts("timeout");
    endtask

    initial begin
        test_reset();
        test_decode_basic();
        test_neutral_clamp();
        test_bad_width();
        test_missing_p2();
        test_reset_mid_p1();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
